// File: rtl/nano_pkg.sv
// nano_pkg: shared types and constants for the nano memory loader.
// Holds the loader FSM state encoding and the default address/data widths.
package nano_pkg;

    localparam int unsigned NANO_ADDR_W = 8;
    localparam int unsigned NANO_DATA_W = 16;

    typedef enum logic [2:0] {
        StCnt,
        StHi,
        StLo,
        StCsum,
        StHold,
        StRun,
        StErr
    } load_state_e;

    // States in which the loader byte port is open.
    function automatic logic accepts_bytes(load_state_e s);
        return (s == StCnt) || (s == StHi) || (s == StLo) || (s == StCsum);
    endfunction

    // States that count as "load in progress" (CPU still held off).
    function automatic logic is_loading(load_state_e s);
        return accepts_bytes(s) || (s == StHold);
    endfunction

endpackage

// File: rtl/nano_mem_loader_if.sv
// nano_mem_loader_if: loader byte stream, CPU memory port and loader status.
// master = the environment (byte source + CPU), slave = nano_mem_loader.
interface nano_mem_loader_if #(
    parameter int unsigned ADDR_W = nano_pkg::NANO_ADDR_W
);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              reload;
    logic [ADDR_W-1:0] cpu_addr;
    logic [15:0]       cpu_dataW;
    logic              cpu_ce;
    logic              cpu_we;
    logic [15:0]       cpu_dataR;
    logic              cpu_rst;
    logic              load_busy;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output in_valid, in_byte, reload, cpu_addr, cpu_dataW, cpu_ce, cpu_we,
        input  in_ready, cpu_dataR, cpu_rst, load_busy, load_err, words_loaded
    );

    modport slave (
        input  in_valid, in_byte, reload, cpu_addr, cpu_dataW, cpu_ce, cpu_we,
        output in_ready, cpu_dataR, cpu_rst, load_busy, load_err, words_loaded
    );

endinterface

// File: rtl/nano_ram.sv
// nano_ram: 2^ADDR_W x DATA_W storage, asynchronous read, one synchronous write port.
// Contents are deliberately not reset so a reset keeps the loaded image.
module nano_ram
    import nano_pkg::*;
#(
    parameter int unsigned ADDR_W = NANO_ADDR_W,
    parameter int unsigned DATA_W = NANO_DATA_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [Depth];

    // Single write port; no reset on the array.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nano_mem_loader.sv
// nano_mem_loader: byte-stream boot loader in front of a 2^ADDR_W x 16 RAM.
// Stream: count byte N (0 = full depth), then N words high byte first to addresses 0..N-1.
// The CPU is held in reset until the image is in, then released after a short hold.
// Optional feature macro NANO_LOAD_CHECKSUM_EN: a trailing XOR checksum byte is required;
// a mismatch parks the loader in an error state with the CPU kept in reset.
module nano_mem_loader
    import nano_pkg::*;
#(
    parameter int unsigned ADDR_W    = NANO_ADDR_W,
    parameter int unsigned BOOT_HOLD = 2
) (
    input logic              ck,
    input logic              rst,
    nano_mem_loader_if.slave bus
);
    localparam int unsigned     CntW    = ADDR_W + 1;
    localparam logic [CntW-1:0] FullCnt = {1'b1, {ADDR_W{1'b0}}};

    load_state_e       state_q, state_d;
    logic [CntW-1:0]   words_q, words_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [CntW-1:0]   words_inc;
    logic [7:0]        hi_q, hi_d;
    logic [3:0]        hold_q, hold_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              xfer;
    logic              load_we;
    logic              cpu_wr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [15:0]       ram_wdata;
`ifdef NANO_LOAD_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              err_q, err_d;
`endif

    assign xfer      = bus.in_valid && ready_q;
    assign words_inc = words_q + CntW'(1);
    // CPU writes only land in RUN; reload on the same edge does not block them.
    assign cpu_wr    = (state_q == StRun) && bus.cpu_ce && bus.cpu_we;

    // Next-state logic; reload overrides everything, including a byte on the same edge.
    always_comb begin
        state_d = state_q;
        words_d = words_q;
        count_d = count_q;
        hi_d    = hi_q;
        hold_d  = hold_q;
        load_we = 1'b0;
`ifdef NANO_LOAD_CHECKSUM_EN
        csum_d  = csum_q;
        err_d   = err_q;
`endif
        if (bus.reload) begin
            state_d = StCnt;
            words_d = '0;
            hold_d  = '0;
`ifdef NANO_LOAD_CHECKSUM_EN
            csum_d  = '0;
            err_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StCnt: begin
                    if (xfer) begin
                        count_d = (bus.in_byte == 8'd0) ? FullCnt : CntW'(bus.in_byte);
                        words_d = '0;
`ifdef NANO_LOAD_CHECKSUM_EN
                        csum_d  = '0;
`endif
                        state_d = StHi;
                    end
                end
                StHi: begin
                    if (xfer) begin
                        hi_d    = bus.in_byte;
`ifdef NANO_LOAD_CHECKSUM_EN
                        csum_d  = csum_q ^ bus.in_byte;
`endif
                        state_d = StLo;
                    end
                end
                StLo: begin
                    if (xfer) begin
                        load_we = 1'b1;
                        words_d = words_inc;
`ifdef NANO_LOAD_CHECKSUM_EN
                        csum_d  = csum_q ^ bus.in_byte;
`endif
                        if (words_inc == count_q) begin
                            hold_d  = '0;
`ifdef NANO_LOAD_CHECKSUM_EN
                            state_d = StCsum;
`else
                            state_d = StHold;
`endif
                        end else begin
                            state_d = StHi;
                        end
                    end
                end
`ifdef NANO_LOAD_CHECKSUM_EN
                StCsum: begin
                    if (xfer) begin
                        hold_d = '0;
                        if (bus.in_byte == csum_q) begin
                            state_d = StHold;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StErr;
                        end
                    end
                end
`endif
                // hold_q runs 0..BOOT_HOLD, so RUN (and cpu_rst low) starts BOOT_HOLD+1
                // edges after the last accepted byte.
                StHold: begin
                    if (hold_q == 4'(BOOT_HOLD)) begin
                        state_d = StRun;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
                StRun, StErr: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = StCnt;
                end
            endcase
        end
        // Outputs are registered off the next state so they switch with the state.
        cpu_rst_d = (state_d != StRun);
        busy_d    = is_loading(state_d);
        ready_d   = accepts_bytes(state_d);
    end

    // Loader FSM and its registered outputs.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q   <= StCnt;
            words_q   <= '0;
            count_q   <= '0;
            hi_q      <= '0;
            hold_q    <= '0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b1;
            ready_q   <= 1'b1;
`ifdef NANO_LOAD_CHECKSUM_EN
            csum_q    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            words_q   <= words_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            hold_q    <= hold_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
`ifdef NANO_LOAD_CHECKSUM_EN
            csum_q    <= csum_d;
            err_q     <= err_d;
`endif
        end
    end

    // RAM write-port mux: loader while loading, CPU in RUN (states never overlap).
    always_comb begin
        ram_we    = load_we || cpu_wr;
        ram_waddr = bus.cpu_addr;
        ram_wdata = bus.cpu_dataW;
        if (load_we) begin
            ram_waddr = words_q[ADDR_W-1:0];
            ram_wdata = {hi_q, bus.in_byte};
        end
    end

    nano_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (NANO_DATA_W)
    ) u_ram (
        .clk_i   (ck),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (bus.cpu_addr),
        .rdata_o (bus.cpu_dataR)
    );

    assign bus.in_ready     = ready_q;
    assign bus.cpu_rst      = cpu_rst_q;
    assign bus.load_busy    = busy_q;
    assign bus.words_loaded = words_q;
`ifdef NANO_LOAD_CHECKSUM_EN
    assign bus.load_err     = err_q;
`else
    assign bus.load_err     = 1'b0;
`endif

endmodule
